// File: rtl/axi_addr_router.sv
// 1-to-N AXI4 address router: the top SEL_W address bits pick a memory-controller port and the remaining bits are forwarded.
// Read and write directions each serve one target at a time, and unmapped targets are answered locally with DECERR.
module axi_addr_router #(
  parameter int N_PORTS  = 3,
  parameter int ADDR_W   = 36,
  parameter int SEL_W    = 2,
  parameter int DATA_W   = 512,
  parameter int ID_W     = 7,
  parameter int MAX_OUTS = 16,
  parameter int WQ_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic [ADDR_W-1:0]                  s_axi_awaddr,
  input  logic [ID_W-1:0]                    s_axi_awid,
  input  logic [7:0]                         s_axi_awlen,
  input  logic [16:0]                        s_axi_awctl,
  input  logic                               s_axi_awvalid,
  output logic                               s_axi_awready,
  input  logic [DATA_W-1:0]                  s_axi_wdata,
  input  logic [DATA_W/8-1:0]                s_axi_wstrb,
  input  logic                               s_axi_wlast,
  input  logic                               s_axi_wvalid,
  output logic                               s_axi_wready,
  output logic [ID_W-1:0]                    s_axi_bid,
  output logic [1:0]                         s_axi_bresp,
  output logic                               s_axi_bvalid,
  input  logic                               s_axi_bready,
  input  logic [ADDR_W-1:0]                  s_axi_araddr,
  input  logic [ID_W-1:0]                    s_axi_arid,
  input  logic [7:0]                         s_axi_arlen,
  input  logic [16:0]                        s_axi_arctl,
  input  logic                               s_axi_arvalid,
  output logic                               s_axi_arready,
  output logic [ID_W-1:0]                    s_axi_rid,
  output logic [DATA_W-1:0]                  s_axi_rdata,
  output logic [1:0]                         s_axi_rresp,
  output logic                               s_axi_rlast,
  output logic                               s_axi_rvalid,
  input  logic                               s_axi_rready,
  output logic [N_PORTS*(ADDR_W-SEL_W)-1:0]  m_axi_awaddr,
  output logic [N_PORTS*ID_W-1:0]            m_axi_awid,
  output logic [N_PORTS*8-1:0]               m_axi_awlen,
  output logic [N_PORTS*17-1:0]              m_axi_awctl,
  output logic [N_PORTS-1:0]                 m_axi_awvalid,
  input  logic [N_PORTS-1:0]                 m_axi_awready,
  output logic [N_PORTS*DATA_W-1:0]          m_axi_wdata,
  output logic [N_PORTS*(DATA_W/8)-1:0]      m_axi_wstrb,
  output logic [N_PORTS-1:0]                 m_axi_wlast,
  output logic [N_PORTS-1:0]                 m_axi_wvalid,
  input  logic [N_PORTS-1:0]                 m_axi_wready,
  input  logic [N_PORTS*ID_W-1:0]            m_axi_bid,
  input  logic [N_PORTS*2-1:0]               m_axi_bresp,
  input  logic [N_PORTS-1:0]                 m_axi_bvalid,
  output logic [N_PORTS-1:0]                 m_axi_bready,
  output logic [N_PORTS*(ADDR_W-SEL_W)-1:0]  m_axi_araddr,
  output logic [N_PORTS*ID_W-1:0]            m_axi_arid,
  output logic [N_PORTS*8-1:0]               m_axi_arlen,
  output logic [N_PORTS*17-1:0]              m_axi_arctl,
  output logic [N_PORTS-1:0]                 m_axi_arvalid,
  input  logic [N_PORTS-1:0]                 m_axi_arready,
  input  logic [N_PORTS*ID_W-1:0]            m_axi_rid,
  input  logic [N_PORTS*DATA_W-1:0]          m_axi_rdata,
  input  logic [N_PORTS*2-1:0]               m_axi_rresp,
  input  logic [N_PORTS-1:0]                 m_axi_rlast,
  input  logic [N_PORTS-1:0]                 m_axi_rvalid,
  output logic [N_PORTS-1:0]                 m_axi_rready
);

  localparam int MA_W = ADDR_W - SEL_W;
  localparam int CW   = $clog2(MAX_OUTS) + 1;
  localparam int QAW  = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int QCW  = $clog2(WQ_DEPTH + 1);
  localparam logic [CW-1:0]    OUTS_MAX = CW'(MAX_OUTS);
  localparam logic [QCW-1:0]   WQ_FULL  = QCW'(WQ_DEPTH);
  localparam logic [QAW-1:0]   WQ_LAST  = QAW'(WQ_DEPTH - 1);
  localparam logic [SEL_W:0]   PORT_LIM = (SEL_W + 1)'(N_PORTS);

  logic [SEL_W-1:0] aw_sel, ar_sel, wr_cur, rd_cur, wq_head;
  logic             aw_err, ar_err, wr_cur_err, rd_cur_err, wq_head_err;
  logic [CW-1:0]    wr_outs, rd_outs;
  logic [SEL_W-1:0] wq_mem [WQ_DEPTH];
  logic [QAW-1:0]   wq_wptr, wq_rptr;
  logic [QCW-1:0]   wq_cnt;
  logic             wq_empty, wq_full;
  logic             aw_gate, aw_port_ready, aw_hs;
  logic             w_gate, w_port_ready, w_pop;
  logic             b_active, b_hs;
  logic             ar_gate, ar_port_ready, ar_hs;
  logic             r_active, r_hs, r_done_hs;
  logic [ID_W-1:0]  err_wid, err_rid;
  logic             err_b_pend, err_r_act;
  logic [7:0]       err_rcnt;

  assign aw_sel      = s_axi_awaddr[ADDR_W-1 -: SEL_W];
  assign ar_sel      = s_axi_araddr[ADDR_W-1 -: SEL_W];
  assign aw_err      = {1'b0, aw_sel} >= PORT_LIM;
  assign ar_err      = {1'b0, ar_sel} >= PORT_LIM;
  assign wr_cur_err  = {1'b0, wr_cur} >= PORT_LIM;
  assign rd_cur_err  = {1'b0, rd_cur} >= PORT_LIM;
  assign wq_head     = wq_mem[wq_rptr];
  assign wq_head_err = {1'b0, wq_head} >= PORT_LIM;
  assign wq_empty    = (wq_cnt == '0);
  assign wq_full     = (wq_cnt == WQ_FULL);

  // Request payloads go to every port; only the valid selects the target.
  assign m_axi_awaddr = {N_PORTS{s_axi_awaddr[MA_W-1:0]}};
  assign m_axi_awid   = {N_PORTS{s_axi_awid}};
  assign m_axi_awlen  = {N_PORTS{s_axi_awlen}};
  assign m_axi_awctl  = {N_PORTS{s_axi_awctl}};
  assign m_axi_wdata  = {N_PORTS{s_axi_wdata}};
  assign m_axi_wstrb  = {N_PORTS{s_axi_wstrb}};
  assign m_axi_wlast  = {N_PORTS{s_axi_wlast}};
  assign m_axi_araddr = {N_PORTS{s_axi_araddr[MA_W-1:0]}};
  assign m_axi_arid   = {N_PORTS{s_axi_arid}};
  assign m_axi_arlen  = {N_PORTS{s_axi_arlen}};
  assign m_axi_arctl  = {N_PORTS{s_axi_arctl}};

  always_comb begin
    aw_gate = resetn && (wr_outs < OUTS_MAX) && !wq_full &&
              ((wr_outs == '0) || (aw_sel == wr_cur)) && (!aw_err || (wr_outs == '0));
    m_axi_awvalid = '0;
    aw_port_ready = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (aw_sel == SEL_W'(k)) begin
        m_axi_awvalid[k] = aw_gate && s_axi_awvalid;
        aw_port_ready    = m_axi_awready[k];
      end
    end
    s_axi_awready = aw_gate && (aw_err || aw_port_ready);
  end

  assign aw_hs = s_axi_awvalid && s_axi_awready;

  // W beats follow the route FIFO head; there is no bypass from a same-cycle AW.
  always_comb begin
    w_gate       = resetn && !wq_empty;
    m_axi_wvalid = '0;
    w_port_ready = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (!wq_head_err && (wq_head == SEL_W'(k))) begin
        m_axi_wvalid[k] = w_gate && s_axi_wvalid;
        w_port_ready    = m_axi_wready[k];
      end
    end
    s_axi_wready = w_gate && (wq_head_err || w_port_ready);
  end

  assign w_pop = s_axi_wvalid && s_axi_wready && s_axi_wlast;

  always_comb begin
    b_active     = resetn && (wr_outs != '0);
    s_axi_bvalid = 1'b0;
    s_axi_bid    = '0;
    s_axi_bresp  = '0;
    m_axi_bready = '0;
    if (wr_cur_err) begin
      s_axi_bvalid = b_active && err_b_pend;
      s_axi_bid    = err_wid;
      s_axi_bresp  = 2'b11;
    end else begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (wr_cur == SEL_W'(k)) begin
          s_axi_bvalid    = b_active && m_axi_bvalid[k];
          s_axi_bid       = m_axi_bid[k*ID_W +: ID_W];
          s_axi_bresp     = m_axi_bresp[k*2 +: 2];
          m_axi_bready[k] = b_active && s_axi_bready;
        end
      end
    end
  end

  assign b_hs = s_axi_bvalid && s_axi_bready;

  always_ff @(posedge clk) begin
    if (aw_hs) wq_mem[wq_wptr] <= aw_sel;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wq_wptr    <= '0;
      wq_rptr    <= '0;
      wq_cnt     <= '0;
      wr_cur     <= '0;
      wr_outs    <= '0;
      err_wid    <= '0;
      err_b_pend <= 1'b0;
    end else begin
      if (aw_hs) begin
        wq_wptr <= (wq_wptr == WQ_LAST) ? '0 : wq_wptr + 1'b1;
        wr_cur  <= aw_sel;
        if (aw_err) err_wid <= s_axi_awid;
      end
      if (w_pop) wq_rptr <= (wq_rptr == WQ_LAST) ? '0 : wq_rptr + 1'b1;
      case ({aw_hs, w_pop})
        2'b10:   wq_cnt <= wq_cnt + 1'b1;
        2'b01:   wq_cnt <= wq_cnt - 1'b1;
        default: wq_cnt <= wq_cnt;
      endcase
      case ({aw_hs, b_hs})
        2'b10:   wr_outs <= wr_outs + 1'b1;
        2'b01:   wr_outs <= wr_outs - 1'b1;
        default: wr_outs <= wr_outs;
      endcase
      if (w_pop && wq_head_err) err_b_pend <= 1'b1;
      else if (b_hs && wr_cur_err) err_b_pend <= 1'b0;
    end
  end

  // Read response mux; an ERR target answers from the local beat generator.
  always_comb begin
    r_active     = resetn && (rd_outs != '0);
    s_axi_rvalid = 1'b0;
    s_axi_rid    = '0;
    s_axi_rdata  = '0;
    s_axi_rresp  = '0;
    s_axi_rlast  = 1'b0;
    m_axi_rready = '0;
    if (rd_cur_err) begin
      s_axi_rvalid = r_active && err_r_act;
      s_axi_rid    = err_rid;
      s_axi_rresp  = 2'b11;
      s_axi_rlast  = (err_rcnt == 8'd0);
    end else begin
      for (int k = 0; k < N_PORTS; k++) begin
        if (rd_cur == SEL_W'(k)) begin
          s_axi_rvalid    = r_active && m_axi_rvalid[k];
          s_axi_rid       = m_axi_rid[k*ID_W +: ID_W];
          s_axi_rdata     = m_axi_rdata[k*DATA_W +: DATA_W];
          s_axi_rresp     = m_axi_rresp[k*2 +: 2];
          s_axi_rlast     = m_axi_rlast[k];
          m_axi_rready[k] = r_active && s_axi_rready;
        end
      end
    end
    r_hs      = s_axi_rvalid && s_axi_rready;
    r_done_hs = r_hs && s_axi_rlast;
  end

  // A burst completing this cycle frees its slot, so a full tracker can accept an AR in the same cycle.
  always_comb begin
    ar_gate = resetn && ((rd_outs < OUTS_MAX) || r_done_hs) &&
              ((rd_outs == '0) || (ar_sel == rd_cur)) && (!ar_err || (rd_outs == '0));
    m_axi_arvalid = '0;
    ar_port_ready = 1'b0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (ar_sel == SEL_W'(k)) begin
        m_axi_arvalid[k] = ar_gate && s_axi_arvalid;
        ar_port_ready    = m_axi_arready[k];
      end
    end
    s_axi_arready = ar_gate && (ar_err || ar_port_ready);
  end

  assign ar_hs = s_axi_arvalid && s_axi_arready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_cur    <= '0;
      rd_outs   <= '0;
      err_rid   <= '0;
      err_rcnt  <= '0;
      err_r_act <= 1'b0;
    end else begin
      if (r_hs && rd_cur_err) begin
        if (err_rcnt == 8'd0) err_r_act <= 1'b0;
        else err_rcnt <= err_rcnt - 8'd1;
      end
      if (ar_hs) begin
        rd_cur <= ar_sel;
        if (ar_err) begin
          err_rid   <= s_axi_arid;
          err_rcnt  <= s_axi_arlen;
          err_r_act <= 1'b1;
        end
      end
      case ({ar_hs, r_done_hs})
        2'b10:   rd_outs <= rd_outs + 1'b1;
        2'b01:   rd_outs <= rd_outs - 1'b1;
        default: rd_outs <= rd_outs;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_addr_router.sv
// Scoreboard bench for axi_addr_router: expected port-side requests and slave-side responses are queued when driven.
// They are popped by a negedge monitor when the matching handshake appears.
module tb_axi_addr_router;

  localparam int NP = 3;
  localparam int AW = 36;
  localparam int SW = 2;
  localparam int DW = 512;
  localparam int IW = 7;
  localparam int MA = AW - SW;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [7:0] s_axi_awlen, s_axi_arlen;
  logic [16:0] s_axi_awctl, s_axi_arctl;
  logic s_axi_awvalid, s_axi_awready, s_axi_arvalid, s_axi_arready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [DW/8-1:0] s_axi_wstrb;
  logic s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic s_axi_bvalid, s_axi_bready, s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [NP*MA-1:0] m_axi_awaddr, m_axi_araddr;
  logic [NP*IW-1:0] m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
  logic [NP*8-1:0] m_axi_awlen, m_axi_arlen;
  logic [NP*17-1:0] m_axi_awctl, m_axi_arctl;
  logic [NP-1:0] m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [NP*DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [NP*(DW/8)-1:0] m_axi_wstrb;
  logic [NP-1:0] m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [NP*2-1:0] m_axi_bresp, m_axi_rresp;
  logic [NP-1:0] m_axi_bvalid, m_axi_bready, m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_addr_router dut (
    .clk(clk), .resetn(resetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen),
    .s_axi_awctl(s_axi_awctl), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen),
    .s_axi_arctl(s_axi_arctl), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awid(m_axi_awid), .m_axi_awlen(m_axi_awlen),
    .m_axi_awctl(m_axi_awctl), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen),
    .m_axi_arctl(m_axi_arctl), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  typedef struct {int port; logic [63:0] addr; logic [6:0] id; logic [7:0] len;} aexp_t;
  typedef struct {int port; logic [63:0] data; logic last;} wexp_t;
  typedef struct {logic [6:0] id; logic [1:0] resp;} bexp_t;
  typedef struct {logic [6:0] id; logic [1:0] resp; logic last; logic [63:0] data;} rexp_t;

  aexp_t aw_q[$], ar_q[$];
  wexp_t w_q[$];
  bexp_t b_q[$];
  rexp_t r_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every handshake seen on either side must match the oldest queued expectation.
  always @(negedge clk) begin
    aexp_t ae;
    wexp_t we;
    bexp_t be;
    rexp_t re;
    if (resetn) begin
      for (int k = 0; k < NP; k++) begin
        if (m_axi_awvalid[k] && m_axi_awready[k]) begin
          checkOutput("aw_expected", 64'(aw_q.size() > 0), 1);
          if (aw_q.size() > 0) begin
            ae = aw_q.pop_front();
            checkOutput("aw_port", k, ae.port);
            checkOutput("aw_addr", 64'(m_axi_awaddr[k*MA +: MA]), ae.addr);
            checkOutput("aw_id", 64'(m_axi_awid[k*IW +: IW]), 64'(ae.id));
            checkOutput("aw_len", 64'(m_axi_awlen[k*8 +: 8]), 64'(ae.len));
          end
        end
        if (m_axi_arvalid[k] && m_axi_arready[k]) begin
          checkOutput("ar_expected", 64'(ar_q.size() > 0), 1);
          if (ar_q.size() > 0) begin
            ae = ar_q.pop_front();
            checkOutput("ar_port", k, ae.port);
            checkOutput("ar_addr", 64'(m_axi_araddr[k*MA +: MA]), ae.addr);
            checkOutput("ar_id", 64'(m_axi_arid[k*IW +: IW]), 64'(ae.id));
          end
        end
        if (m_axi_wvalid[k] && m_axi_wready[k]) begin
          checkOutput("w_expected", 64'(w_q.size() > 0), 1);
          if (w_q.size() > 0) begin
            we = w_q.pop_front();
            checkOutput("w_port", k, we.port);
            checkOutput("w_data", m_axi_wdata[k*DW +: 64], we.data);
            checkOutput("w_last", 64'(m_axi_wlast[k]), 64'(we.last));
          end
        end
      end
      if (s_axi_bvalid && s_axi_bready) begin
        checkOutput("b_expected", 64'(b_q.size() > 0), 1);
        if (b_q.size() > 0) begin
          be = b_q.pop_front();
          checkOutput("b_id", 64'(s_axi_bid), 64'(be.id));
          checkOutput("b_resp", 64'(s_axi_bresp), 64'(be.resp));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        checkOutput("r_expected", 64'(r_q.size() > 0), 1);
        if (r_q.size() > 0) begin
          re = r_q.pop_front();
          checkOutput("r_id", 64'(s_axi_rid), 64'(re.id));
          checkOutput("r_resp", 64'(s_axi_rresp), 64'(re.resp));
          checkOutput("r_last", 64'(s_axi_rlast), 64'(re.last));
          checkOutput("r_data", s_axi_rdata[63:0], re.data);
        end
      end
    end
  end

  task automatic sendAw(input logic [AW-1:0] addr, input logic [6:0] id, input logic [7:0] len);
    int port;
    int c;
    port = int'(addr[AW-1 -: SW]);
    if (port < NP) aw_q.push_back('{port, 64'(addr[MA-1:0]), id, len});
    s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = len; s_axi_awvalid = 1'b1;
    c = 0;
    @(negedge clk);
    while (!s_axi_awready && c < 50) begin @(negedge clk); c++; end
    checkOutput("aw_ready", 64'(s_axi_awready), 1);
    tick();
    s_axi_awvalid = 1'b0;
  endtask

  task automatic sendAr(input logic [AW-1:0] addr, input logic [6:0] id, input logic [7:0] len);
    int port;
    int c;
    port = int'(addr[AW-1 -: SW]);
    if (port < NP) ar_q.push_back('{port, 64'(addr[MA-1:0]), id, len});
    s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = len; s_axi_arvalid = 1'b1;
    c = 0;
    @(negedge clk);
    while (!s_axi_arready && c < 50) begin @(negedge clk); c++; end
    checkOutput("ar_ready", 64'(s_axi_arready), 1);
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic sendW(input int port, input int beats, input logic [63:0] base, input bit give_last);
    int c;
    logic [NP-1:0] lane;
    lane = (port < NP) ? NP'(1 << port) : '0;
    for (int b = 0; b < beats; b++) begin
      s_axi_wdata = '0;
      s_axi_wdata[63:0] = base + 64'(b);
      s_axi_wstrb = '1;
      s_axi_wlast = give_last && (b == beats - 1);
      s_axi_wvalid = 1'b1;
      if (port < NP) w_q.push_back('{port, base + 64'(b), s_axi_wlast});
      c = 0;
      @(negedge clk);
      while (!s_axi_wready && c < 50) begin @(negedge clk); c++; end
      checkOutput("w_ready", 64'(s_axi_wready), 1);
      checkOutput("w_lane", 64'(m_axi_wvalid), 64'(lane));
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast = 1'b0;
  endtask

  task automatic respondB(input int port, input logic [6:0] id, input logic [1:0] resp);
    int c;
    b_q.push_back('{id, resp});
    m_axi_bvalid[port] = 1'b1;
    m_axi_bid[port*IW +: IW] = id;
    m_axi_bresp[port*2 +: 2] = resp;
    c = 0;
    @(negedge clk);
    while (!m_axi_bready[port] && c < 50) begin @(negedge clk); c++; end
    checkOutput("b_port_ready", 64'(m_axi_bready[port]), 1);
    tick();
    m_axi_bvalid[port] = 1'b0;
  endtask

  task automatic respondR(input int port, input logic [6:0] id, input int beats, input logic [63:0] base);
    int c;
    for (int b = 0; b < beats; b++) begin
      m_axi_rvalid[port] = 1'b1;
      m_axi_rid[port*IW +: IW] = id;
      m_axi_rresp[port*2 +: 2] = 2'b00;
      m_axi_rlast[port] = (b == beats - 1);
      m_axi_rdata[port*DW +: DW] = '0;
      m_axi_rdata[port*DW +: 64] = base + 64'(b);
      r_q.push_back('{id, 2'b00, (b == beats - 1), base + 64'(b)});
      c = 0;
      @(negedge clk);
      while (!m_axi_rready[port] && c < 50) begin @(negedge clk); c++; end
      checkOutput("r_port_ready", 64'(m_axi_rready[port]), 1);
      tick();
    end
    m_axi_rvalid[port] = 1'b0;
    m_axi_rlast[port] = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int c;
    c = 0;
    while ((aw_q.size() + ar_q.size() + w_q.size() + b_q.size() + r_q.size()) != 0 && c < 100) begin
      tick();
      c++;
    end
    checkOutput(tag, 64'(aw_q.size() + ar_q.size() + w_q.size() + b_q.size() + r_q.size()), 0);
  endtask

  task automatic applyStimulus();
    // Reset with requests pending: nothing may be offered or accepted.
    resetn = 1'b0;
    s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0; s_axi_awctl = 17'h1_2345; s_axi_awvalid = 1'b1;
    s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0; s_axi_arctl = 17'h0_0abc; s_axi_arvalid = 1'b1;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    m_axi_awready = '1; m_axi_wready = '1; m_axi_arready = '1;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = '0;
    m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = '0; m_axi_rvalid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_awready", 64'(s_axi_awready), 0);
    checkOutput("rst_m_awvalid", 64'(m_axi_awvalid), 0);
    checkOutput("rst_arready", 64'(s_axi_arready), 0);
    checkOutput("rst_m_arvalid", 64'(m_axi_arvalid), 0);
    checkOutput("rst_wready", 64'(s_axi_wready), 0);
    checkOutput("rst_bvalid", 64'(s_axi_bvalid), 0);
    checkOutput("rst_rvalid", 64'(s_axi_rvalid), 0);
    checkOutput("rst_m_ready", 64'({m_axi_bready, m_axi_rready}), 0);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0; s_axi_wvalid = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b1;
    tick();

    // T1: port1 write burst, 4 beats, B id passes through.
    sendAw(36'h4_0000_0100, 7'h11, 8'd3);
    sendW(1, 4, 64'h1000, 1'b1);
    respondB(1, 7'h11, 2'b01);
    waitDrain("t1_drain");

    // T2: a port2 AW waits behind an outstanding port0 write until its B completes.
    sendAw(36'h0_0000_0200, 7'h01, 8'd0);
    sendW(0, 1, 64'h2000, 1'b1);
    aw_q.push_back('{2, 64'h0_0000_0040, 7'h02, 8'd0});
    s_axi_awaddr = 36'h8_0000_0040; s_axi_awid = 7'h02; s_axi_awlen = 8'd0; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t2_stall_rdy", 64'(s_axi_awready), 0);
      checkOutput("t2_stall_mv", 64'(m_axi_awvalid), 0);
    end
    tick();
    respondB(0, 7'h01, 2'b00);
    @(negedge clk);
    checkOutput("t2_issue_rdy", 64'(s_axi_awready), 1);
    checkOutput("t2_issue_mv", 64'(m_axi_awvalid), 64'(3'b100));
    tick();
    s_axi_awvalid = 1'b0;
    sendW(2, 1, 64'h2100, 1'b1);
    respondB(2, 7'h02, 2'b10);
    waitDrain("t2_drain");

    // T3: sixteen outstanding reads fill the tracker; a final rlast frees a slot in the same cycle.
    for (int i = 0; i < 16; i++) sendAr(36'h4_0000_1000 + 36'(i * 64), 7'(i), 8'd0);
    ar_q.push_back('{1, 64'h0_0000_2000, 7'd16, 8'd0});
    s_axi_araddr = 36'h4_0000_2000; s_axi_arid = 7'd16; s_axi_arlen = 8'd0; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("t3_full_rdy", 64'(s_axi_arready), 0);
      checkOutput("t3_full_mv", 64'(m_axi_arvalid), 0);
    end
    tick();
    m_axi_rvalid[1] = 1'b1; m_axi_rlast[1] = 1'b1; m_axi_rid[IW +: IW] = 7'd0;
    m_axi_rresp[2 +: 2] = 2'b00;
    m_axi_rdata[DW +: 64] = 64'h3000;
    r_q.push_back('{7'd0, 2'b00, 1'b1, 64'h3000});
    @(negedge clk);
    checkOutput("t3_same_cycle", 64'(s_axi_arready), 1);
    tick();
    s_axi_arvalid = 1'b0; m_axi_rvalid[1] = 1'b0; m_axi_rlast[1] = 1'b0;
    for (int i = 1; i <= 16; i++) respondR(1, 7'(i), 1, 64'h3000 + 64'(i));
    waitDrain("t3_drain");

    // T4: unmapped read target returns arlen+1 DECERR beats locally.
    s_axi_rready = 1'b0;
    sendAr(36'hC_0000_0000, 7'd5, 8'd2);
    @(negedge clk);
    checkOutput("t4_rvalid", 64'(s_axi_rvalid), 1);
    checkOutput("t4_rid", 64'(s_axi_rid), 5);
    checkOutput("t4_rlast0", 64'(s_axi_rlast), 0);
    for (int b = 0; b < 3; b++) r_q.push_back('{7'd5, 2'b11, (b == 2), 64'h0});
    tick();
    s_axi_rready = 1'b1;
    waitDrain("t4_drain");
    checkOutput("t4_rvalid_end", 64'(s_axi_rvalid), 0);

    // T5: unmapped write target swallows W beats and answers DECERR with the latched id.
    sendAw(36'hC_0000_0000, 7'd9, 8'd1);
    @(negedge clk);
    checkOutput("t5_b_early", 64'(s_axi_bvalid), 0);
    tick();
    b_q.push_back('{7'd9, 2'b11});
    sendW(3, 2, 64'h5000, 1'b1);
    waitDrain("t5_drain");

    // T6: reset in the middle of a burst, then a clean write to port0.
    sendAw(36'h0_0000_0300, 7'h03, 8'd3);
    sendW(0, 2, 64'h6000, 1'b0);
    s_axi_wvalid = 1'b1;
    s_axi_awaddr = 36'h0_0000_0400; s_axi_awvalid = 1'b1;
    s_axi_araddr = 36'h0_0000_0400; s_axi_arvalid = 1'b1;
    resetn = 1'b0;
    #1;
    checkOutput("t6_wready", 64'(s_axi_wready), 0);
    checkOutput("t6_m_wvalid", 64'(m_axi_wvalid), 0);
    checkOutput("t6_awready", 64'(s_axi_awready), 0);
    checkOutput("t6_m_awvalid", 64'(m_axi_awvalid), 0);
    checkOutput("t6_arready", 64'(s_axi_arready), 0);
    s_axi_wvalid = 1'b0; s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    aw_q.delete(); ar_q.delete(); w_q.delete(); b_q.delete(); r_q.delete();
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    tick();
    sendAw(36'h0_0000_0500, 7'h04, 8'd0);
    sendW(0, 1, 64'h7000, 1'b1);
    respondB(0, 7'h04, 2'b00);
    waitDrain("t6_drain");
  endtask

  initial begin
    applyStimulus();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout wanted completion");
    $fatal(1);
  end

endmodule
